fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_INIT, default 0, reset value of the fetch PC.
REQ-002 SHALL have parameter DEPTH, default 4, fetch-queue entries; power of two, >= 2.
REQ-003 SHALL have port CLK  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port nRST  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port ihit  input  1  instruction memory returned imemload this cycle.
REQ-006 SHALL have port imemload  input  32  instruction word from memory.
REQ-007 SHALL have port redirect  input  1  branch/jump/jr taken; flush and refetch.
REQ-008 SHALL have port redirect_pc  input  32  new fetch address when redirect=1.
REQ-009 SHALL have port halt  input  1  stop issuing fetches (sticky).
REQ-010 SHALL have port deq  input  1  consumer takes head instruction this cycle.
REQ-011 SHALL have port imemREN  output  1  fetch request.
REQ-012 SHALL have port imemaddr  output  32  fetch address.
REQ-013 SHALL have port valid  output  1  queue head holds an instruction.
REQ-014 SHALL have port instr  output  32  head instruction word.
REQ-015 SHALL have port instr_pc  output  32  address of head instruction.
REQ-016 SHALL have port instr_npc  output  32  instr_pc + 4.
REQ-017 SHALL have port count  output  $clog2(DEPTH+1)  current queue occupancy.

Function
REQ-018 SHALL hold a fetch PC register fpc; imemaddr = fpc combinationally.
REQ-019 SHALL drive imemREN = !full && !halted, where full = (count == DEPTH) from registered state; a same-cycle deq does not unblock a full queue.
REQ-020 SHALL enqueue {imemload, fpc} and set fpc <= fpc + 4 (mod 2^32) when imemREN && ihit && !redirect.
REQ-021 SHALL ignore ihit when imemREN = 0; fpc and queue unchanged.
REQ-022 SHALL hold fpc stable while imemREN && !ihit && !redirect (request pending).
REQ-023 SHALL dequeue the head when deq && valid && !redirect; deq with valid = 0 is ignored.
REQ-024 SHALL leave count unchanged on simultaneous enqueue and dequeue; otherwise +1 per enqueue, -1 per dequeue.
REQ-025 SHALL implement read/write pointers of $clog2(DEPTH) bits wrapping modulo DEPTH.
REQ-026 SHALL present the head show-ahead: valid = (count != 0); instr/instr_pc from registered storage; instr_npc = instr_pc + 4.
REQ-027 SHALL give one-cycle latency: word accepted on ihit in cycle N is visible at the head in cycle N+1 if the queue was empty.
REQ-028 SHALL on redirect: count <= 0, both pointers <= 0, fpc <= redirect_pc; any same-cycle ihit word and deq are discarded.
REQ-029 SHALL set sticky flag halted <= 1 when halt = 1; imemREN = 0 from the next cycle until reset.
REQ-030 SHALL continue draining the queue via deq while halted.
REQ-031 SHALL apply both actions when redirect and halt coincide: queue flushed, fpc <= redirect_pc, halted <= 1.
REQ-032 SHALL drive instr, instr_pc, instr_npc as don't-care-free values (last storage contents) when valid = 0; consumers qualify with valid.

Reset
REQ-033 SHALL on nRST = 0, immediately and regardless of clock: fpc <= PC_INIT, count <= 0, pointers <= 0, halted <= 0, storage <= 0.
REQ-034 SHALL therefore output after reset: imemREN = 1, imemaddr = PC_INIT, valid = 0, count = 0, instr = 0, instr_pc = 0, instr_npc = 4.
REQ-035 SHALL abandon any pending request when reset asserts mid-fetch; the returned word is not enqueued.

Verification
REQ-036 Reset, ihit=1 every cycle, deq=0, DEPTH=4 -> addresses 0,4,8,C enqueued, count 1..4, imemREN=0 at count=4, imemaddr holds 0x10.
REQ-037 Full queue, deq=1 one cycle -> count 3 next cycle, imemREN=1 only then, next enqueue pc 0x10; pointer wrap to slot 0 verified.
REQ-038 count=2, ihit=1 and deq=1 same cycle -> count stays 2, head advances to next pc.
REQ-039 count=3, ihit=1, deq=1, redirect=1, redirect_pc=0x200 -> next cycle count=0, valid=0, imemaddr=0x200; next ihit enqueues pc 0x200, instr_npc=0x204.
REQ-040 halt=1 with count=2 -> imemREN=0 forever; two deq drain to valid=0; ihit afterwards ignored.
REQ-041 nRST pulsed low mid-cycle with count=3, fpc=0x40 -> outputs immediately per REQ-034, imemaddr=PC_INIT.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch PC with a show-ahead fetch queue
// Fetches sequentially until the queue is full or halted; redirect flushes and refetches.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0,
  parameter int          DEPTH   = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       ihit,
  input  logic [31:0]                imemload,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       halt,
  input  logic                       deq,
  output logic                       imemREN,
  output logic [31:0]                imemaddr,
  output logic                       valid,
  output logic [31:0]                instr,
  output logic [31:0]                instr_pc,
  output logic [31:0]                instr_npc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   fpc;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [CW-1:0] cnt;
  logic          halted;
  logic [31:0]   mem_data [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];

  logic full;
  logic enq;
  logic dq;

  // Fullness comes from registered count only, so a same-cycle deq cannot unblock a fetch.
  assign full      = (cnt == CW'(DEPTH));
  assign imemREN   = !full && !halted;
  assign imemaddr  = fpc;
  assign enq       = imemREN && ihit && !redirect;
  assign dq        = deq && valid && !redirect;
  assign valid     = (cnt != '0);
  assign count     = cnt;
  assign instr     = mem_data[rptr];
  assign instr_pc  = mem_pc[rptr];
  assign instr_npc = instr_pc + 32'd4;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fpc    <= PC_INIT;
      cnt    <= '0;
      rptr   <= '0;
      wptr   <= '0;
      halted <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else begin
      if (halt) halted <= 1'b1;
      if (redirect) begin
        // Storage is left intact; only occupancy and pointers are cleared.
        fpc  <= redirect_pc;
        cnt  <= '0;
        rptr <= '0;
        wptr <= '0;
      end else begin
        if (enq) begin
          mem_data[wptr] <= imemload;
          mem_pc[wptr]   <= fpc;
          wptr           <= wptr + PW'(1);
          fpc            <= fpc + 32'd4;
        end
        if (dq) rptr <= rptr + PW'(1);
        if (enq && !dq)      cnt <= cnt + CW'(1);
        else if (!enq && dq) cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
// Memory returns pc ^ K so each expected instruction word follows from its expected pc.
module tb_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        deq;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_npc;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.PC_INIT(32'h0), .DEPTH(4)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .deq(deq),
    .imemREN(imemREN), .imemaddr(imemaddr), .valid(valid), .instr(instr),
    .instr_pc(instr_pc), .instr_npc(instr_npc), .count(count)
  );

  always #5 CLK = ~CLK;
  assign imemload = imemaddr ^ K;

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 1'b0; ihit = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0; deq = 1'b0;
    @(negedge CLK);
    total++; if (imemREN !== 1'b1) begin bad++; $display("FAIL reset_ren got=%0b exp=1", imemREN); end
    total++; if (imemaddr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imemaddr); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", valid); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", instr_pc); end
    total++; if (instr_npc !== 32'h4) begin bad++; $display("FAIL reset_npc got=%h exp=4", instr_npc); end
    nRST = 1'b1;
  endtask

  task automatic test_fill();
    ihit = 1'b1; deq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (imemREN !== 1'b1) begin bad++; $display("FAIL fill_ren%0d got=%0b exp=1", i, imemREN); end
      total++; if (imemaddr !== 32'(4 * i)) begin bad++; $display("FAIL fill_addr%0d got=%h exp=%h", i, imemaddr, 4 * i); end
      tick();
      total++; if (count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count%0d got=%0d exp=%0d", i, count, i + 1); end
    end
    total++; if (imemREN !== 1'b0) begin bad++; $display("FAIL full_ren got=%0b exp=0", imemREN); end
    total++; if (imemaddr !== 32'h10) begin bad++; $display("FAIL full_addr got=%h exp=10", imemaddr); end
    total++; if (instr_pc !== 32'h0 || instr !== K) begin bad++; $display("FAIL full_head got=%h/%h exp=0/%h", instr_pc, instr, K); end
    tick();
    total++; if (count !== 3'd4 || imemaddr !== 32'h10) begin bad++; $display("FAIL full_ignore got=%0d/%h exp=4/10", count, imemaddr); end
  endtask

  task automatic test_full_deq();
    ihit = 1'b0; deq = 1'b1;
    tick();
    total++; if (count !== 3'd3) begin bad++; $display("FAIL fdeq_count got=%0d exp=3", count); end
    total++; if (imemREN !== 1'b1) begin bad++; $display("FAIL fdeq_ren got=%0b exp=1", imemREN); end
    total++; if (instr_pc !== 32'h4) begin bad++; $display("FAIL fdeq_head got=%h exp=4", instr_pc); end
    ihit = 1'b1; deq = 1'b0;
    tick();
    total++; if (count !== 3'd4 || imemaddr !== 32'h14) begin bad++; $display("FAIL wrap_enq got=%0d/%h exp=4/14", count, imemaddr); end
    ihit = 1'b0; deq = 1'b1;
    tick();
    total++; if (instr_pc !== 32'h8 || count !== 3'd3) begin bad++; $display("FAIL drain1 got=%h/%0d exp=8/3", instr_pc, count); end
    tick();
    total++; if (instr_pc !== 32'hC || count !== 3'd2) begin bad++; $display("FAIL drain2 got=%h/%0d exp=C/2", instr_pc, count); end
  endtask

  task automatic test_back_to_back();
    ihit = 1'b1; deq = 1'b1;
    tick();
    total++; if (count !== 3'd2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", count); end
    total++; if (instr_pc !== 32'h10 || instr !== (32'h10 ^ K)) begin bad++; $display("FAIL b2b_wrap_head got=%h/%h exp=10/%h", instr_pc, instr, 32'h10 ^ K); end
    total++; if (imemaddr !== 32'h18) begin bad++; $display("FAIL b2b_addr got=%h exp=18", imemaddr); end
    deq = 1'b0;
    tick();
    total++; if (count !== 3'd3) begin bad++; $display("FAIL b2b_count3 got=%0d exp=3", count); end
  endtask

  task automatic test_redirect();
    ihit = 1'b1; deq = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    total++; if (count !== 3'd0 || valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%0d/%0b exp=0/0", count, valid); end
    total++; if (imemaddr !== 32'h200) begin bad++; $display("FAIL redir_addr got=%h exp=200", imemaddr); end
    redirect = 1'b0; deq = 1'b0;
    tick();
    total++; if (count !== 3'd1 || valid !== 1'b1) begin bad++; $display("FAIL redir_enq got=%0d/%0b exp=1/1", count, valid); end
    total++; if (instr_pc !== 32'h200 || instr_npc !== 32'h204) begin bad++; $display("FAIL redir_pc got=%h/%h exp=200/204", instr_pc, instr_npc); end
    total++; if (instr !== (32'h200 ^ K)) begin bad++; $display("FAIL redir_instr got=%h exp=%h", instr, 32'h200 ^ K); end
  endtask

  task automatic test_halt();
    tick();
    total++; if (count !== 3'd2) begin bad++; $display("FAIL halt_pre got=%0d exp=2", count); end
    ihit = 1'b0; halt = 1'b1;
    tick();
    total++; if (imemREN !== 1'b0 || count !== 3'd2) begin bad++; $display("FAIL halt_ren got=%0b/%0d exp=0/2", imemREN, count); end
    halt = 1'b0; ihit = 1'b1; deq = 1'b1;
    tick();
    total++; if (count !== 3'd1 || instr_pc !== 32'h204) begin bad++; $display("FAIL halt_drain1 got=%0d/%h exp=1/204", count, instr_pc); end
    total++; if (imemREN !== 1'b0 || imemaddr !== 32'h208) begin bad++; $display("FAIL halt_sticky got=%0b/%h exp=0/208", imemREN, imemaddr); end
    tick();
    total++; if (valid !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL halt_drain2 got=%0b/%0d exp=0/0", valid, count); end
    deq = 1'b0;
    tick();
    total++; if (count !== 3'd0 || imemaddr !== 32'h208) begin bad++; $display("FAIL halt_ihit got=%0d/%h exp=0/208", count, imemaddr); end
  endtask

  task automatic test_async_reset();
    nRST = 1'b0; ihit = 1'b0; deq = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    total++; if (imemREN !== 1'b1) begin bad++; $display("FAIL rst_clears_halt got=%0b exp=1", imemREN); end
    ihit = 1'b1; deq = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    deq = 1'b0;
    tick();
    tick();
    total++; if (count !== 3'd3 || imemaddr !== 32'h40) begin bad++; $display("FAIL arst_pre got=%0d/%h exp=3/40", count, imemaddr); end
    #2 nRST = 1'b0;
    #1;
    total++; if (imemREN !== 1'b1 || imemaddr !== 32'h0) begin bad++; $display("FAIL arst_fetch got=%0b/%h exp=1/0", imemREN, imemaddr); end
    total++; if (valid !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL arst_queue got=%0b/%0d exp=0/0", valid, count); end
    total++; if (instr !== 32'h0 || instr_pc !== 32'h0 || instr_npc !== 32'h4) begin bad++; $display("FAIL arst_head got=%h/%h/%h exp=0/0/4", instr, instr_pc, instr_npc); end
    @(negedge CLK);
    nRST = 1'b1; ihit = 1'b0;
    tick();
    total++; if (count !== 3'd0 || imemaddr !== 32'h0) begin bad++; $display("FAIL arst_abandon got=%0d/%h exp=0/0", count, imemaddr); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_deq();
    test_back_to_back();
    test_redirect();
    test_halt();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
